// File: rtl/mem_if.sv
// Shared memory port of the multi-cycle core: a single req/ready channel for fetch and data.
interface mem_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core; fetch and loads/stores share one req/ready memory port.
// Define JUMP_EN to execute j (opcode 6'b000010); without it that opcode halts the core.
module multicycle_datapath #(
  parameter int                ADDR_W   = 32,
  parameter int                NREG     = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  mem_if.master             bus,
  output logic              halted,
  output logic              instr_done,
  output logic [31:0]       instr_count,
  output logic [ADDR_W-1:0] pc_o
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;
`ifdef JUMP_EN
  localparam logic JUMP_ON = 1'b1;
`else
  localparam logic JUMP_ON = 1'b0;
`endif

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state_r, state_next_s;

  logic [ADDR_W-1:0] pc_r, branch_tgt_s, jump_tgt_s, mem_addr_s;
  logic [31:0] ir_r, a_r, b_r, alu_out_r, mdr_r, instr_count_r;
  logic [31:0] regs_r [NREG];
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, wr_idx_s;
  logic [31:0] imm_s, alu_s, wb_data_s, mem_wdata_s;
  logic        legal_s, aligned_s, retire_s, mem_req_s, mem_we_s;

  function automatic logic reg_ok(input logic [4:0] idx);
    reg_ok = 32'(idx) < 32'(NREG);
  endfunction

  // Instruction field extraction and derived targets
  always_comb begin
    op_s     = ir_r[31:26];
    rs_s     = ir_r[25:21];
    rt_s     = ir_r[20:16];
    rd_s     = ir_r[15:11];
    funct_s  = ir_r[5:0];
    imm_s    = {{16{ir_r[15]}}, ir_r[15:0]};
    wr_idx_s = (op_s == OP_RTYPE) ? rd_s : rt_s;
    wb_data_s = (op_s == OP_LW) ? mdr_r : alu_out_r;
  end

  // PC already points past the branch when EXEC runs, so offsets are relative to PC+4
  assign branch_tgt_s = pc_r + ADDR_W'({imm_s[29:0], 2'b00});
  assign jump_tgt_s   = ADDR_W'((32'(pc_r) & 32'hF000_0000) | {4'b0000, ir_r[25:0], 2'b00});
  assign aligned_s    = (alu_out_r[1:0] == 2'b00);

  // Opcode/funct legality and register-range check
  always_comb begin
    legal_s = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal_s = reg_ok(rs_s) & reg_ok(rt_s) & reg_ok(rd_s);
          default: legal_s = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: legal_s = reg_ok(rs_s) & reg_ok(rt_s);
      OP_J:    legal_s = JUMP_ON;
      default: legal_s = 1'b0;
    endcase
  end

  // ALU: R-type ops, otherwise base + sign-extended immediate
  always_comb begin
    alu_s = a_r + imm_s;
    if (op_s == OP_RTYPE) begin
      case (funct_s)
        FN_SUB:  alu_s = a_r - b_r;
        FN_AND:  alu_s = a_r & b_r;
        FN_OR:   alu_s = a_r | b_r;
        FN_SLT:  alu_s = {31'd0, $signed(a_r) < $signed(b_r)};
        default: alu_s = a_r + b_r;
      endcase
    end else begin
      alu_s = a_r + imm_s;
    end
  end

  // Next-state and retire decode
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      FETCH:  state_next_s = bus.mem_ready ? DECODE : FETCH;
      DECODE: state_next_s = legal_s ? EXEC : HALT;
      EXEC: begin
        case (op_s)
          OP_RTYPE, OP_ADDI: state_next_s = WB;
          OP_LW, OP_SW:      state_next_s = MEM;
          OP_BEQ, OP_J: begin
            state_next_s = FETCH;
            retire_s     = 1'b1;
          end
          default: state_next_s = HALT;
        endcase
      end
      MEM: begin
        if (!aligned_s) begin
          state_next_s = HALT;
        end else if (bus.mem_ready) begin
          state_next_s = (op_s == OP_SW) ? FETCH : WB;
          retire_s     = (op_s == OP_SW);
        end else begin
          state_next_s = MEM;
        end
      end
      WB: begin
        state_next_s = FETCH;
        retire_s     = 1'b1;
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = HALT;
    endcase
  end

  // Memory port drive; held constant by the state registers while a request waits
  always_comb begin
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = 32'd0;
    if (rst) begin
      mem_req_s = 1'b0;
    end else if (state_r == FETCH) begin
      mem_req_s  = 1'b1;
      mem_addr_s = pc_r;
    end else if (state_r == MEM && aligned_s) begin
      mem_req_s   = 1'b1;
      mem_we_s    = (op_s == OP_SW);
      mem_addr_s  = alu_out_r[ADDR_W-1:0];
      mem_wdata_s = (op_s == OP_SW) ? b_r : 32'd0;
    end else begin
      mem_req_s = 1'b0;
    end
  end

  assign bus.mem_req   = mem_req_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign halted        = (state_r == HALT);
  assign instr_done    = retire_s;
  assign instr_count   = instr_count_r;
  assign pc_o          = pc_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= FETCH;
    else     state_r <= state_next_s;
  end

  // Datapath registers: PC, IR, operand latches, ALU result, MDR, retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= PC_RESET;
      ir_r          <= 32'd0;
      a_r           <= 32'd0;
      b_r           <= 32'd0;
      alu_out_r     <= 32'd0;
      mdr_r         <= 32'd0;
      instr_count_r <= 32'd0;
    end else begin
      case (state_r)
        FETCH: begin
          if (bus.mem_ready) begin
            ir_r <= bus.mem_rdata;
            pc_r <= pc_r + ADDR_W'(32'd4);
          end
        end
        DECODE: begin
          a_r <= regs_r[rs_s[RW-1:0]];
          b_r <= regs_r[rt_s[RW-1:0]];
        end
        EXEC: begin
          alu_out_r <= alu_s;
          if (op_s == OP_BEQ && a_r == b_r) pc_r <= branch_tgt_s;
          else if (op_s == OP_J && JUMP_ON) pc_r <= jump_tgt_s;
        end
        MEM: begin
          if (aligned_s && bus.mem_ready && op_s == OP_LW) mdr_r <= bus.mem_rdata;
        end
        default: ;
      endcase
      if (retire_s) instr_count_r <= instr_count_r + 32'd1;
    end
  end

  // Register file; entry 0 is never written so it always reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= 32'd0;
    end else if (state_r == WB && wr_idx_s != 5'd0) begin
      regs_r[wr_idx_s[RW-1:0]] <= wb_data_s;
    end
  end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath with a wait-state memory model.
module tb_multicycle_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_if #(.ADDR_W(32)) bus ();
  mem_if #(.ADDR_W(32)) bus8 ();

  logic        halted, instr_done, halted8, instr_done8;
  logic [31:0] instr_count, pc_o, instr_count8, pc_o8;
  logic [31:0] instr8 = {6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'b100000};

  multicycle_datapath #(.ADDR_W(32), .NREG(32), .PC_RESET(32'h10)) dut (
    .clk(clk), .rst(rst), .bus(bus), .halted(halted), .instr_done(instr_done),
    .instr_count(instr_count), .pc_o(pc_o));

  multicycle_datapath #(.ADDR_W(32), .NREG(8), .PC_RESET(32'h0)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .halted(halted8), .instr_done(instr_done8),
    .instr_count(instr_count8), .pc_o(pc_o8));

  assign bus8.mem_rdata = instr8;
  assign bus8.mem_ready = 1'b1;

  // Memory: program ROM plus a small data RAM overlay below 0x10 with its own wait count
  logic [31:0] rom [256];
  logic [31:0] ram [4];
  logic [3:0]  ram_v;
  int fetch_wait = 0, data_wait = 0, wcnt, wr_cnt, data_req_cnt;
  logic [31:0] last_waddr, last_wdata;
  logic is_data;
  int total = 0, bad = 0;

  assign is_data = bus.mem_addr < 32'h10;
  assign bus.mem_ready = bus.mem_req && (wcnt >= (is_data ? data_wait : fetch_wait));
  assign bus.mem_rdata = (is_data && ram_v[bus.mem_addr[3:2]]) ? ram[bus.mem_addr[3:2]]
                                                                : rom[bus.mem_addr[9:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0; ram_v <= 4'd0; wr_cnt <= 0; data_req_cnt <= 0;
      last_waddr <= 32'd0; last_wdata <= 32'd0;
    end else if (bus.mem_req) begin
      if (is_data) data_req_cnt <= data_req_cnt + 1;
      if (bus.mem_ready) begin
        wcnt <= 0;
        if (bus.mem_we) begin
          wr_cnt <= wr_cnt + 1;
          last_waddr <= bus.mem_addr;
          last_wdata <= bus.mem_wdata;
          if (is_data) begin
            ram[bus.mem_addr[3:2]] <= bus.mem_wdata;
            ram_v[bus.mem_addr[3:2]] <= 1'b1;
          end
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'hFC00_0000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[4] = enc_i(6'b001000, 5'd0, 5'd1, 16'd1);
    fetch_wait = 0; data_wait = 0;
    apply_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    fetch_wait = 1000;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h14) begin bad++;
      $display("FAIL stall_fetch: req=%b addr=%h expected req=1 addr=00000014", bus.mem_req, bus.mem_addr); end
    total++; if (instr_count !== 32'd1) begin bad++; $display("FAIL pre_reset_count: got %0d expected 1", instr_count); end
    rst = 1'b1;
    #1;
    total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0) begin bad++;
      $display("FAIL reset_port: req=%b we=%b addr=%h expected 0 0 0", bus.mem_req, bus.mem_we, bus.mem_addr); end
    total++; if (pc_o !== 32'h10 || instr_count !== 32'd0) begin bad++;
      $display("FAIL reset_regs: pc=%h count=%0d expected 00000010 0", pc_o, instr_count); end
    total++; if (halted !== 1'b0 || instr_done !== 1'b0) begin bad++;
      $display("FAIL reset_flags: halted=%b done=%b expected 0 0", halted, instr_done); end
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_hold_req: got %b expected 0", bus.mem_req); end
    rst = 1'b0;
    fetch_wait = 0;
    #1;
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin bad++;
      $display("FAIL first_fetch: req=%b addr=%h expected 1 00000010", bus.mem_req, bus.mem_addr); end
    @(negedge clk); #1;
    total++; if (pc_o !== 32'h14) begin bad++; $display("FAIL fetch_after_reset: pc=%h expected 00000014", pc_o); end
  endtask

  task automatic test_arith();
    clear_rom();
    rom[4] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
    rom[5] = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);
    rom[6] = enc_r(5'd1, 5'd2, 5'd3, 6'b100000);
    rom[7] = enc_r(5'd2, 5'd1, 5'd4, 6'b101010);
    apply_reset();
    repeat (15) @(posedge clk);
    @(negedge clk); #1;
    total++; if (instr_count !== 32'd3) begin bad++; $display("FAIL count_15: got %0d expected 3", instr_count); end
    @(negedge clk); #1;
    total++; if (instr_count !== 32'd4) begin bad++; $display("FAIL count_16: got %0d expected 4", instr_count); end
    total++; if (dut.regs_r[3] !== 32'd2) begin bad++; $display("FAIL add_r3: got %h expected 00000002", dut.regs_r[3]); end
    total++; if (dut.regs_r[4] !== 32'd1) begin bad++; $display("FAIL slt_r4: got %h expected 00000001", dut.regs_r[4]); end
    total++; if (dut.regs_r[2] !== 32'hFFFF_FFFD) begin bad++; $display("FAIL addi_neg: got %h expected fffffffd", dut.regs_r[2]); end
    repeat (4) @(negedge clk); #1;
    total++; if (halted !== 1'b1 || instr_count !== 32'd4) begin bad++;
      $display("FAIL illegal_halt: halted=%b count=%0d expected 1 4", halted, instr_count); end
  endtask

  task automatic test_alu();
    clear_rom();
    rom[4]  = enc_i(6'b001000, 5'd0, 5'd1, 16'd12);
    rom[5]  = enc_i(6'b001000, 5'd0, 5'd2, 16'd10);
    rom[6]  = enc_r(5'd2, 5'd1, 5'd3, 6'b100010);
    rom[7]  = enc_r(5'd1, 5'd2, 5'd4, 6'b100100);
    rom[8]  = enc_r(5'd1, 5'd2, 5'd5, 6'b100101);
    rom[9]  = enc_r(5'd1, 5'd2, 5'd6, 6'b101010);
    rom[10] = enc_i(6'b000100, 5'd1, 5'd2, 16'd4);
    rom[11] = enc_r(5'd1, 5'd1, 5'd0, 6'b100000);
    rom[12] = enc_r(5'd0, 5'd1, 5'd7, 6'b100010);
    rom[13] = enc_r(5'd7, 5'd2, 5'd8, 6'b101010);
    apply_reset();
    for (int c = 0; c < 100 && !halted; c++) @(negedge clk);
    #1;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL alu_timeout: halted=%b expected 1", halted); end
    total++; if (instr_count !== 32'd10 || pc_o !== 32'h3C) begin bad++;
      $display("FAIL alu_retire: count=%0d pc=%h expected 10 0000003c", instr_count, pc_o); end
    total++; if (dut.regs_r[3] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub: got %h expected fffffffe", dut.regs_r[3]); end
    total++; if (dut.regs_r[4] !== 32'd8) begin bad++; $display("FAIL and: got %h expected 00000008", dut.regs_r[4]); end
    total++; if (dut.regs_r[5] !== 32'd14) begin bad++; $display("FAIL or: got %h expected 0000000e", dut.regs_r[5]); end
    total++; if (dut.regs_r[6] !== 32'd0) begin bad++; $display("FAIL slt_false: got %h expected 00000000", dut.regs_r[6]); end
    total++; if (dut.regs_r[0] !== 32'd0) begin bad++; $display("FAIL r0_write: got %h expected 00000000", dut.regs_r[0]); end
    total++; if (dut.regs_r[8] !== 32'd1) begin bad++; $display("FAIL slt_signed: got %h expected 00000001", dut.regs_r[8]); end
  endtask

  task automatic test_mem_wait();
    int done_at [3];
    int ndone = 0, we_cycles = 0, we_bad = 0;
    clear_rom();
    rom[4] = enc_i(6'b001000, 5'd0, 5'd3, 16'd2);
    rom[5] = enc_i(6'b101011, 5'd0, 5'd3, 16'd8);
    rom[6] = enc_i(6'b100011, 5'd0, 5'd5, 16'd8);
    fetch_wait = 0; data_wait = 2;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      #1;
      if (instr_done && ndone < 3) begin done_at[ndone] = c; ndone++; end
      if (bus.mem_req && bus.mem_we) begin
        we_cycles++;
        if (bus.mem_addr !== 32'h8 || bus.mem_wdata !== 32'h2) we_bad++;
      end
      @(negedge clk);
    end
    total++; if (ndone !== 3) begin bad++; $display("FAIL mem_retire_timeout: got %0d retires expected 3", ndone); end
    else begin
      total++; if (done_at[1] - done_at[0] !== 6) begin bad++;
        $display("FAIL sw_latency: got %0d expected 6", done_at[1] - done_at[0]); end
      total++; if (done_at[2] - done_at[1] !== 7) begin bad++;
        $display("FAIL lw_latency: got %0d expected 7", done_at[2] - done_at[1]); end
    end
    total++; if (we_cycles !== 3 || we_bad !== 0) begin bad++;
      $display("FAIL sw_hold: cycles=%0d unstable=%0d expected 3 0", we_cycles, we_bad); end
    total++; if (wr_cnt !== 1 || last_waddr !== 32'h8 || last_wdata !== 32'h2) begin bad++;
      $display("FAIL sw_write: n=%0d addr=%h data=%h expected 1 00000008 00000002", wr_cnt, last_waddr, last_wdata); end
    total++; if (dut.regs_r[5] !== 32'd2) begin bad++; $display("FAIL lw_r5: got %h expected 00000002", dut.regs_r[5]); end
    data_wait = 0;
  endtask

  task automatic test_beq_loop();
    clear_rom();
    rom[4] = enc_i(6'b000100, 5'd0, 5'd0, 16'hFFFF);
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      total++; if (instr_done !== 1'b1) begin bad++; $display("FAIL beq_done_%0d: got %b expected 1", k, instr_done); end
      @(negedge clk); #1;
      total++; if (pc_o !== 32'h10 || bus.mem_addr !== 32'h10 || bus.mem_req !== 1'b1) begin bad++;
        $display("FAIL beq_pc_%0d: pc=%h addr=%h req=%b expected 00000010 00000010 1", k, pc_o, bus.mem_addr, bus.mem_req); end
      total++; if (instr_count !== 32'(k) || instr_done !== 1'b0) begin bad++;
        $display("FAIL beq_count_%0d: count=%0d done=%b expected %0d 0", k, instr_count, instr_done, k); end
    end
  endtask

  task automatic test_misalign();
    clear_rom();
    rom[4] = enc_i(6'b100011, 5'd0, 5'd1, 16'd2);
    apply_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL misalign_req: got %b expected 0", bus.mem_req); end
    repeat (4) @(negedge clk); #1;
    total++; if (halted !== 1'b1 || data_req_cnt !== 0 || instr_count !== 32'd0) begin bad++;
      $display("FAIL misalign_halt: halted=%b dreq=%0d count=%0d expected 1 0 0", halted, data_req_cnt, instr_count); end
  endtask

  task automatic test_nreg_range();
    instr8 = enc_r(5'd0, 5'd0, 5'd9, 6'b100000);
    apply_reset();
    @(negedge clk); #1;
    total++; if (halted8 !== 1'b0) begin bad++; $display("FAIL nreg_early: got %b expected 0", halted8); end
    @(negedge clk); #1;
    total++; if (halted8 !== 1'b1 || instr_count8 !== 32'd0) begin bad++;
      $display("FAIL nreg_halt: halted=%b count=%0d expected 1 0", halted8, instr_count8); end
  endtask

  task automatic test_jump();
    clear_rom();
    rom[4] = {6'b000010, 26'h40};
    apply_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
`ifdef JUMP_EN
    total++; if (pc_o !== 32'h100 || bus.mem_addr !== 32'h100 || instr_count !== 32'd1) begin bad++;
      $display("FAIL jump_taken: pc=%h addr=%h count=%0d expected 00000100 00000100 1", pc_o, bus.mem_addr, instr_count); end
`else
    total++; if (halted !== 1'b1 || instr_count !== 32'd0) begin bad++;
      $display("FAIL jump_illegal: halted=%b count=%0d expected 1 0", halted, instr_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_arith();
    test_alu();
    test_mem_wait();
    test_beq_loop();
    test_misalign();
    test_nreg_range();
    test_jump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
